// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller.
package dmem_access_ctrl_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Value returned in o_RData when an SC finds no matching reservation
    localparam logic [31:0] SC_FAIL = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_LR    = 2'd2,
        OP_SC    = 2'd3
    } op_t;

    // Loads reject 011/110/111; stores accept only byte/half/word.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW));
        else
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores, extract/extend for loads, alignment check.
// Store side works on the incoming request; load side works on the latched
// access and the bus read word.
module dmem_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  st_f3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_wdata_lane,
    output logic [3:0]  st_byte_en,
    output logic        misaligned,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Alignment depends only on access size (f3[1:0]) and the low address bits
    always_comb begin
        misaligned = 1'b0;
        case (st_f3[1:0])
            2'b01:   misaligned = st_off[0];
            2'b10:   misaligned = (st_off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Replicate store data across lanes so the bus only needs the byte enables
    always_comb begin
        st_wdata_lane = st_wdata;
        st_byte_en    = 4'b0000;
        case (st_f3)
            F3_SB: begin
                st_wdata_lane = {4{st_wdata[7:0]}};
                st_byte_en    = 4'b0001 << st_off;
            end
            F3_SH: begin
                st_wdata_lane = {2{st_wdata[15:0]}};
                st_byte_en    = st_off[1] ? 4'b1100 : 4'b0011;
            end
            F3_SW: begin
                st_wdata_lane = st_wdata;
                st_byte_en    = 4'b1111;
            end
            default: begin
                st_wdata_lane = st_wdata;
                st_byte_en    = 4'b0000;
            end
        endcase
        if (!is_store)
            st_byte_en = 4'b0000;
    end

    // Select the addressed lane and sign/zero extend it
    always_comb begin
        ld_shift = ld_word >> {ld_off, 3'b000};
        ld_byte  = ld_shift[7:0];
        ld_half  = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data  = 32'd0;
        case (ld_f3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LW:   ld_data = ld_word;
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: loads, stores and LR/SC with bus handshake.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a request; rejects/completes trivial cases
// BUSY    | strobe held on the bus until ack, timeout or flush
// DONE    | result presented for one cycle while the pipeline advances
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_MemRead,
    input  logic              i_MemWrite,
    input  logic              i_atomic,
    input  logic [2:0]        i_f3,
    input  logic [ADDR_W-1:0] i_Addr,
    input  logic [31:0]       i_WData,
    input  logic              i_Flush,
    output logic              o_Stall,
    output logic [31:0]       o_RData,
    output logic              o_Ex_misaligned,
    output logic              o_Ex_access,
    output logic [ADDR_W-1:0] o_DM_Addr,
    output logic [31:0]       o_DM_WData,
    output logic [3:0]        o_DM_ByteEn,
    output logic              o_DM_Rd,
    output logic              o_DM_Wr,
    input  logic              i_DM_Ack,
    input  logic [31:0]       i_DM_RData
);

    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;
    logic [2:0]          f3_q;
    op_t                 op_q, op_d;
    logic [31:0]         rdata_q;
    logic                resv_valid_q;
    logic [ADDR_W-3:0]   resv_addr_q;

    logic        req;
    logic        is_sc;
    logic        resv_hit;
    logic        illegal;
    logic        misaligned;
    logic [31:0] st_wdata_lane;
    logic [3:0]  st_byte_en;
    logic [31:0] ld_data;

    logic        accept;
    logic        complete;
    logic        sc_fail;

    assign req      = i_MemRead | i_MemWrite;
    assign is_sc    = i_atomic & i_MemWrite;
    assign resv_hit = resv_valid_q && (resv_addr_q == i_Addr[ADDR_W-1:2]);
    assign illegal  = f3_illegal(i_MemWrite, i_f3);
    assign op_d     = i_atomic ? (i_MemWrite ? OP_SC : OP_LR)
                               : (i_MemWrite ? OP_STORE : OP_LOAD);

    dmem_lane_align u_lane_align (
        .is_store      (i_MemWrite),
        .st_f3         (i_f3),
        .st_off        (i_Addr[1:0]),
        .st_wdata      (i_WData),
        .st_wdata_lane (st_wdata_lane),
        .st_byte_en    (st_byte_en),
        .misaligned    (misaligned),
        .ld_f3         (f3_q),
        .ld_off        (addr_q[1:0]),
        .ld_word       (i_DM_RData),
        .ld_data       (ld_data)
    );

    // Next-state and per-cycle control; exceptions are single-cycle pulses
    always_comb begin
        state_d         = state_q;
        o_Stall         = 1'b0;
        o_Ex_misaligned = 1'b0;
        o_Ex_access     = 1'b0;
        accept          = 1'b0;
        complete        = 1'b0;
        sc_fail         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && !i_Flush) begin
                    if (misaligned) begin
                        o_Ex_misaligned = 1'b1;
                    end else if (illegal) begin
                        o_Ex_access = 1'b1;
                    end else if (is_sc && !resv_hit) begin
                        sc_fail = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        o_Stall = 1'b1;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (i_Flush) begin
                    state_d = ST_IDLE;
                end else if (i_DM_Ack) begin
                    complete = 1'b1;
                    o_Stall  = 1'b1;
                    state_d  = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    o_Ex_access = 1'b1;
                    o_Stall     = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    o_Stall = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes come from state so reset or flush removes them without a clock
    assign o_DM_Rd   = (state_q == ST_BUSY) && !i_Flush &&
                       ((op_q == OP_LOAD) || (op_q == OP_LR));
    assign o_DM_Wr   = (state_q == ST_BUSY) && !i_Flush &&
                       ((op_q == OP_STORE) || (op_q == OP_SC));
    assign o_DM_Addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign o_DM_WData  = wdata_q;
    assign o_DM_ByteEn = be_q;
    assign o_RData     = sc_fail ? SC_FAIL : rdata_q;

    // FSM state and wait-cycle counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_BUSY) && (state_d == ST_BUSY))
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
        end
    end

    // Access registers loaded on accept, result register loaded on ack
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            op_q    <= OP_LOAD;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= i_Addr;
                wdata_q <= st_wdata_lane;
                be_q    <= st_byte_en;
                f3_q    <= i_f3;
                op_q    <= op_d;
            end
            if (complete)
                rdata_q <= (op_q == OP_SC) ? 32'd0 : ld_data;
        end
    end

    // LR/SC reservation; flush and any SC attempt take priority over setting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else if (i_Flush) begin
            resv_valid_q <= 1'b0;
        end else if (sc_fail || (accept && is_sc)) begin
            resv_valid_q <= 1'b0;
        end else if (complete && (op_q == OP_LR)) begin
            resv_valid_q <= 1'b1;
            resv_addr_q  <= addr_q[ADDR_W-1:2];
        end else if (complete && (op_q == OP_STORE) &&
                     (addr_q[ADDR_W-1:2] == resv_addr_q)) begin
            resv_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with hand-computed expectations.
module tb_dmem_access_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_MemRead, i_MemWrite, i_atomic, i_Flush;
    logic [2:0]  i_f3;
    logic [31:0] i_Addr, i_WData;
    logic        o_Stall, o_Ex_misaligned, o_Ex_access, o_DM_Rd, o_DM_Wr;
    logic [31:0] o_RData, o_DM_Addr, o_DM_WData;
    logic [3:0]  o_DM_ByteEn;
    logic        i_DM_Ack;
    logic [31:0] i_DM_RData;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    dmem_access_ctrl #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_MemRead       (i_MemRead),
        .i_MemWrite      (i_MemWrite),
        .i_atomic        (i_atomic),
        .i_f3            (i_f3),
        .i_Addr          (i_Addr),
        .i_WData         (i_WData),
        .i_Flush         (i_Flush),
        .o_Stall         (o_Stall),
        .o_RData         (o_RData),
        .o_Ex_misaligned (o_Ex_misaligned),
        .o_Ex_access     (o_Ex_access),
        .o_DM_Addr       (o_DM_Addr),
        .o_DM_WData      (o_DM_WData),
        .o_DM_ByteEn     (o_DM_ByteEn),
        .o_DM_Rd         (o_DM_Rd),
        .o_DM_Wr         (o_DM_Wr),
        .i_DM_Ack        (i_DM_Ack),
        .i_DM_RData      (i_DM_RData)
    );

    task automatic cyc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_req;
        i_MemRead  = 1'b0;
        i_MemWrite = 1'b0;
        i_atomic   = 1'b0;
        i_Flush    = 1'b0;
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic at,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata);
        i_MemRead  = rd;
        i_MemWrite = wr;
        i_atomic   = at;
        i_f3       = f3;
        i_Addr     = addr;
        i_WData    = wdata;
    endtask

    // Request, ack in the first BUSY cycle, sample DONE. Bus outputs are
    // sampled in the BUSY cycle.
    task automatic run_access(input logic rd, input logic wr, input logic at,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] bus_word,
                              output logic [31:0] result, output int stalls,
                              output logic b_rd, output logic b_wr,
                              output logic [31:0] b_addr, output logic [31:0] b_wdata,
                              output logic [3:0] b_be);
        stalls = 0;
        cyc;
        drive_req(rd, wr, at, f3, addr, wdata);
        #1;
        if (o_Stall) stalls++;
        cyc;
        clear_req;
        i_DM_Ack   = 1'b1;
        i_DM_RData = bus_word;
        #1;
        if (o_Stall) stalls++;
        b_rd = o_DM_Rd; b_wr = o_DM_Wr; b_addr = o_DM_Addr;
        b_wdata = o_DM_WData; b_be = o_DM_ByteEn;
        cyc;
        i_DM_Ack   = 1'b0;
        i_DM_RData = 32'd0;
        #1;
        if (o_Stall) stalls++;
        result = o_RData;
    endtask

    task automatic test_reset;
        checks++; if (o_Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", o_Stall); end
        checks++; if ({o_DM_Rd, o_DM_Wr} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {o_DM_Rd, o_DM_Wr}); end
        checks++; if (o_RData !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", o_RData); end
        checks++; if ({o_DM_ByteEn, o_DM_Addr, o_DM_WData} !== 68'd0) begin errors++; $display("FAIL reset_bus got %h %h %h exp 0", o_DM_ByteEn, o_DM_Addr, o_DM_WData); end
        checks++; if ({o_Ex_misaligned, o_Ex_access} !== 2'b00) begin errors++; $display("FAIL reset_ex got %b exp 00", {o_Ex_misaligned, o_Ex_access}); end
    endtask

    task automatic test_lw;
        int stall_n = 0;
        int rd_bad  = 0;
        cyc;
        drive_req(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'd0);
        #1;
        if (o_Stall) stall_n++;
        checks++; if (o_DM_Rd !== 1'b0) begin errors++; $display("FAIL lw_req_strobe got %b exp 0", o_DM_Rd); end
        cyc;
        clear_req;
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) begin
                i_DM_Ack   = 1'b1;
                i_DM_RData = 32'hDEADBEEF;
            end
            #1;
            if (o_Stall) stall_n++;
            if (o_DM_Rd !== 1'b1 || o_DM_Wr !== 1'b0 || o_DM_Addr !== 32'h100 || o_DM_ByteEn !== 4'h0) rd_bad++;
            cyc;
        end
        i_DM_Ack   = 1'b0;
        i_DM_RData = 32'd0;
        #1;
        checks++; if (stall_n !== 4) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 4", stall_n); end
        checks++; if (rd_bad !== 0) begin errors++; $display("FAIL lw_rd_steady got %0d bad cycles exp 0", rd_bad); end
        checks++; if (o_Stall !== 1'b0) begin errors++; $display("FAIL lw_done_stall got %b exp 0", o_Stall); end
        checks++; if (o_RData !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", o_RData); end
        checks++; if (o_DM_Rd !== 1'b0) begin errors++; $display("FAIL lw_done_strobe got %b exp 0", o_DM_Rd); end
        cyc;
        checks++; if (o_Stall !== 1'b0 || o_DM_Rd !== 1'b0) begin errors++; $display("FAIL lw_back_idle got stall %b rd %b exp 0 0", o_Stall, o_DM_Rd); end
    endtask

    task automatic test_load_extend;
        logic [31:0] r, ba, bw;
        int s;
        logic br, bwr;
        logic [3:0] be;
        run_access(1'b1, 1'b0, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FFFFFF, r, s, br, bwr, ba, bw, be);
        checks++; if (r !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got %h exp ffffff80", r); end
        checks++; if (s !== 2) begin errors++; $display("FAIL lb_latency got %0d stall cycles exp 2", s); end
        checks++; if (ba !== 32'h100 || br !== 1'b1) begin errors++; $display("FAIL lb_bus got addr %h rd %b exp 100 1", ba, br); end
        run_access(1'b1, 1'b0, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FFFFFF, r, s, br, bwr, ba, bw, be);
        checks++; if (r !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got %h exp 00000080", r); end
        run_access(1'b1, 1'b0, 1'b0, 3'b001, 32'h102, 32'd0, 32'h80011234, r, s, br, bwr, ba, bw, be);
        checks++; if (r !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sext got %h exp ffff8001", r); end
        run_access(1'b1, 1'b0, 1'b0, 3'b101, 32'h100, 32'd0, 32'h80011234, r, s, br, bwr, ba, bw, be);
        checks++; if (r !== 32'h00001234) begin errors++; $display("FAIL lhu_zext got %h exp 00001234", r); end
    endtask

    task automatic test_store_lanes;
        logic [31:0] r, ba, bw;
        int s;
        int wr_n = 0;
        logic br, bwr;
        logic [3:0] be;
        cyc;
        drive_req(1'b0, 1'b1, 1'b0, 3'b001, 32'h102, 32'h1234ABCD);
        #1;
        if (o_DM_Wr) wr_n++;
        cyc;
        clear_req;
        #1;
        if (o_DM_Wr) wr_n++;
        checks++; if (o_DM_WData !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", o_DM_WData); end
        checks++; if (o_DM_ByteEn !== 4'b1100) begin errors++; $display("FAIL sh_byteen got %b exp 1100", o_DM_ByteEn); end
        checks++; if (o_DM_Addr !== 32'h100 || o_DM_Rd !== 1'b0) begin errors++; $display("FAIL sh_addr got %h rd %b exp 100 0", o_DM_Addr, o_DM_Rd); end
        cyc;
        i_DM_Ack = 1'b1;
        #1;
        if (o_DM_Wr) wr_n++;
        cyc;
        i_DM_Ack = 1'b0;
        #1;
        if (o_DM_Wr) wr_n++;
        checks++; if (wr_n !== 2) begin errors++; $display("FAIL sh_wr_cycles got %0d exp 2", wr_n); end
        checks++; if (o_Stall !== 1'b0) begin errors++; $display("FAIL sh_done_stall got %b exp 0", o_Stall); end
        run_access(1'b0, 1'b1, 1'b0, 3'b000, 32'h101, 32'hAAAABB55, 32'd0, r, s, br, bwr, ba, bw, be);
        checks++; if (bw !== 32'h55555555 || be !== 4'b0010 || bwr !== 1'b1) begin errors++; $display("FAIL sb_lanes got %h %b wr %b exp 55555555 0010 1", bw, be, bwr); end
        run_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h104, 32'hCAFEF00D, 32'd0, r, s, br, bwr, ba, bw, be);
        checks++; if (bw !== 32'hCAFEF00D || be !== 4'b1111 || ba !== 32'h104) begin errors++; $display("FAIL sw_lanes got %h %b %h exp cafef00d 1111 104", bw, be, ba); end
    endtask

    task automatic test_misaligned_illegal;
        cyc;
        drive_req(1'b1, 1'b0, 1'b0, 3'b010, 32'h102, 32'd0);
        #1;
        checks++; if (o_Ex_misaligned !== 1'b1 || o_Stall !== 1'b0) begin errors++; $display("FAIL lw_mis_pulse got ex %b stall %b exp 1 0", o_Ex_misaligned, o_Stall); end
        cyc;
        clear_req;
        #1;
        checks++; if (o_Ex_misaligned !== 1'b0 || o_DM_Rd !== 1'b0 || o_Stall !== 1'b0) begin errors++; $display("FAIL lw_mis_after got ex %b rd %b stall %b exp 0 0 0", o_Ex_misaligned, o_DM_Rd, o_Stall); end
        drive_req(1'b0, 1'b1, 1'b0, 3'b001, 32'h101, 32'd0);
        #1;
        checks++; if (o_Ex_misaligned !== 1'b1 || o_Ex_access !== 1'b0) begin errors++; $display("FAIL sh_mis got mis %b acc %b exp 1 0", o_Ex_misaligned, o_Ex_access); end
        cyc;
        drive_req(1'b1, 1'b0, 1'b0, 3'b011, 32'h100, 32'd0);
        #1;
        checks++; if (o_Ex_access !== 1'b1 || o_Stall !== 1'b0) begin errors++; $display("FAIL ld_illegal got acc %b stall %b exp 1 0", o_Ex_access, o_Stall); end
        cyc;
        drive_req(1'b0, 1'b1, 1'b0, 3'b100, 32'h100, 32'd0);
        #1;
        checks++; if (o_Ex_access !== 1'b1 || o_Ex_misaligned !== 1'b0) begin errors++; $display("FAIL st_illegal got acc %b mis %b exp 1 0", o_Ex_access, o_Ex_misaligned); end
        cyc;
        clear_req;
        #1;
        checks++; if (o_Ex_access !== 1'b0 || o_DM_Wr !== 1'b0) begin errors++; $display("FAIL illegal_after got acc %b wr %b exp 0 0", o_Ex_access, o_DM_Wr); end
    endtask

    task automatic sc_expect_fail(input string name);
        cyc;
        drive_req(1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 32'h77);
        #1;
        checks++; if (o_RData !== 32'd1 || o_Stall !== 1'b0) begin errors++; $display("FAIL %s got rdata %h stall %b exp 1 0", name, o_RData, o_Stall); end
        cyc;
        clear_req;
        #1;
        checks++; if (o_DM_Wr !== 1'b0) begin errors++; $display("FAIL %s_nowrite got wr %b exp 0", name, o_DM_Wr); end
    endtask

    task automatic test_lr_sc;
        logic [31:0] r, ba, bw;
        int s;
        logic br, bwr;
        logic [3:0] be;
        run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'd0, 32'h11, r, s, br, bwr, ba, bw, be);
        checks++; if (r !== 32'h11 || br !== 1'b1) begin errors++; $display("FAIL lr_load got %h rd %b exp 11 1", r, br); end
        run_access(1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 32'h77, 32'hFFFFFFFF, r, s, br, bwr, ba, bw, be);
        checks++; if (bwr !== 1'b1 || bw !== 32'h77 || ba !== 32'h200) begin errors++; $display("FAIL sc_bus got wr %b %h %h exp 1 77 200", bwr, bw, ba); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL sc_ok_rdata got %h exp 0", r); end
        sc_expect_fail("sc_second");
        run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'd0, 32'h22, r, s, br, bwr, ba, bw, be);
        run_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h204, 32'h5, 32'd0, r, s, br, bwr, ba, bw, be);
        run_access(1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 32'h77, 32'd0, r, s, br, bwr, ba, bw, be);
        checks++; if (r !== 32'd0 || bwr !== 1'b1) begin errors++; $display("FAIL sc_other_word got %h wr %b exp 0 1", r, bwr); end
        run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'd0, 32'h22, r, s, br, bwr, ba, bw, be);
        run_access(1'b0, 1'b1, 1'b0, 3'b000, 32'h202, 32'h5, 32'd0, r, s, br, bwr, ba, bw, be);
        sc_expect_fail("sc_after_store");
        run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'd0, 32'h22, r, s, br, bwr, ba, bw, be);
        cyc;
        i_Flush = 1'b1;
        cyc;
        i_Flush = 1'b0;
        sc_expect_fail("sc_after_flush");
    endtask

    task automatic test_timeout;
        cyc;
        drive_req(1'b1, 1'b0, 1'b0, 3'b010, 32'h300, 32'd0);
        cyc;
        clear_req;
        for (int i = 1; i <= 16; i++) begin
            #1;
            checks++; if (o_Ex_access !== (i == 16) || o_DM_Rd !== 1'b1 || o_Stall !== 1'b1) begin errors++; $display("FAIL timeout_busy%0d got acc %b rd %b stall %b exp %b 1 1", i, o_Ex_access, o_DM_Rd, o_Stall, (i == 16)); end
            cyc;
        end
        #1;
        checks++; if (o_DM_Rd !== 1'b0 || o_Stall !== 1'b0 || o_Ex_access !== 1'b0) begin errors++; $display("FAIL timeout_idle got rd %b stall %b acc %b exp 0 0 0", o_DM_Rd, o_Stall, o_Ex_access); end
    endtask

    task automatic test_flush_busy;
        logic [31:0] r, ba, bw;
        int s;
        logic br, bwr;
        logic [3:0] be;
        cyc;
        drive_req(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'd0);
        cyc;
        clear_req;
        i_Flush = 1'b1;
        #1;
        checks++; if (o_DM_Rd !== 1'b0 || o_Stall !== 1'b0 || o_Ex_access !== 1'b0) begin errors++; $display("FAIL flush_busy got rd %b stall %b acc %b exp 0 0 0", o_DM_Rd, o_Stall, o_Ex_access); end
        cyc;
        i_Flush    = 1'b0;
        i_DM_Ack   = 1'b1;
        i_DM_RData = 32'h12345678;
        #1;
        checks++; if (o_Stall !== 1'b0 || o_DM_Rd !== 1'b0) begin errors++; $display("FAIL late_ack got stall %b rd %b exp 0 0", o_Stall, o_DM_Rd); end
        cyc;
        i_DM_Ack = 1'b0;
        #1;
        checks++; if (o_RData === 32'h12345678) begin errors++; $display("FAIL late_ack_rdata got %h exp not 12345678", o_RData); end
        run_access(1'b1, 1'b0, 1'b0, 3'b010, 32'h108, 32'd0, 32'h0BADF00D, r, s, br, bwr, ba, bw, be);
        checks++; if (r !== 32'h0BADF00D || s !== 2) begin errors++; $display("FAIL after_flush_load got %h stalls %0d exp 0badf00d 2", r, s); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r, ba, bw;
        int s;
        logic br, bwr;
        logic [3:0] be;
        run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'd0, 32'h33, r, s, br, bwr, ba, bw, be);
        cyc;
        drive_req(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'd0);
        cyc;
        clear_req;
        #1;
        checks++; if (o_DM_Rd !== 1'b1) begin errors++; $display("FAIL pre_reset_rd got %b exp 1", o_DM_Rd); end
        #1;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_DM_Rd !== 1'b0 || o_DM_Wr !== 1'b0 || o_Stall !== 1'b0) begin errors++; $display("FAIL async_reset got rd %b wr %b stall %b exp 0 0 0", o_DM_Rd, o_DM_Wr, o_Stall); end
        #3;
        i_rst_n = 1'b1;
        sc_expect_fail("sc_after_reset");
    endtask

    initial begin
        clear_req;
        i_f3       = 3'b000;
        i_Addr     = 32'd0;
        i_WData    = 32'd0;
        i_DM_Ack   = 1'b0;
        i_DM_RData = 32'd0;
        i_rst_n    = 1'b0;
        #12;
        test_reset;
        i_rst_n = 1'b1;
        test_lw;
        test_load_extend;
        test_store_lanes;
        test_misaligned_illegal;
        test_lr_sc;
        test_timeout;
        test_flush_busy;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
